// File: rtl/cpu_pkg.sv
// Shared CPU-subsystem types: arbiter FSM states, requester identities and
// the default RAM geometry used by the MAR, RAM, controller and arbiter.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } arb_state_e;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_PROG = 1'b1
    } req_id_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters (CPU, loader), the RAM and the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface ram_arbiter_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
);

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              prog_req;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic [DATA_W-1:0] prog_rdata;
    logic              prog_ack;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        input  prog_req, prog_we, prog_addr, prog_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        output prog_rdata, prog_ack,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_req, cpu_addr,
        output prog_req, prog_we, prog_addr, prog_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        input  prog_rdata, prog_ack,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/ram_arbiter_arb_pick.sv
// Tie-break between eligible CPU and loader requests.
// RAM_ARB_RR_EN selects round-robin on last_grant; otherwise the CPU wins ties.
module arb_pick
    import cpu_pkg::*;
(
    input  logic    cpu_req_i,
    input  logic    prog_req_i,
`ifdef RAM_ARB_RR_EN
    input  req_id_e last_grant_i,
`endif
    output logic    valid_o,
    output req_id_e winner_o
);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        valid_o  = cpu_req_i | prog_req_i;
        winner_o = REQ_CPU;
        if (cpu_req_i && prog_req_i) begin
`ifdef RAM_ARB_RR_EN
            winner_o = (last_grant_i == REQ_CPU) ? REQ_PROG : REQ_CPU;
`else
            winner_o = REQ_CPU;
`endif
        end else if (prog_req_i) begin
            winner_o = REQ_PROG;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the 16x8 RAM between CPU reads and loader reads/writes; one access per
// 3 cycles, non-preemptive. RAM_ARB_RR_EN enables round-robin tie-break.
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    req_id_e           winner_q, winner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] prog_rdata_q, prog_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              prog_ack_q, prog_ack_d;

    logic              cpu_elig, prog_elig;
    logic              pick_valid;
    req_id_e           pick_winner;

    // A requester still holding req during its own ack cycle sits out one cycle.
    assign cpu_elig  = bus.cpu_req  & ~cpu_ack_q;
    assign prog_elig = bus.prog_req & ~prog_ack_q;

`ifdef RAM_ARB_RR_EN
    req_id_e last_grant_q, last_grant_d;

    arb_pick u_pick (
        .cpu_req_i    (cpu_elig),
        .prog_req_i   (prog_elig),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && pick_valid) last_grant_d = pick_winner;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= REQ_PROG;
        else     last_grant_q <= last_grant_d;
    end
`else
    arb_pick u_pick (
        .cpu_req_i  (cpu_elig),
        .prog_req_i (prog_elig),
        .valid_o    (pick_valid),
        .winner_o   (pick_winner)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            winner_q     <= REQ_CPU;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            prog_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            prog_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            prog_rdata_q <= prog_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            prog_ack_q   <= prog_ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = ISSUE;
                    winner_d = pick_winner;
                end
            end
            ISSUE:   state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_addr_d   = ram_addr_q;
        ram_we_d     = ram_we_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        prog_rdata_d = prog_rdata_q;
        cpu_ack_d    = 1'b0;
        prog_ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (pick_winner == REQ_PROG) begin
                        ram_addr_d  = bus.prog_addr;
                        ram_we_d    = bus.prog_we;
                        ram_wdata_d = bus.prog_wdata;
                    end else begin
                        ram_addr_d  = bus.cpu_addr;
                        ram_we_d    = 1'b0;
                        ram_wdata_d = '0;
                    end
                end
            end
            ISSUE: ram_we_d = 1'b0;
            DATA: begin
                if (winner_q == REQ_CPU) begin
                    cpu_rdata_d = bus.ram_rdata;
                    cpu_ack_d   = 1'b1;
                end else begin
                    prog_rdata_d = bus.ram_rdata;
                    prog_ack_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.prog_rdata = prog_rdata_q;
    assign bus.prog_ack   = prog_ack_q;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed latencies and data.
module tb_ram_arbiter;
    import cpu_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int we_count = 0;
    int pack_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM environment: read data valid one cycle after address capture.
    logic [DW-1:0] env_mem [16];
    logic [DW-1:0] sb_mem  [16];

    always @(posedge clk) begin
        if (bus.ram_we) env_mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= env_mem[bus.ram_addr];
    end

    always @(negedge clk) begin
        if (!rst && bus.ram_we)   we_count++;
        if (!rst && bus.prog_ack) pack_count++;
    end

    // Transaction-level model: a grant in a free cycle c occupies the RAM
    // until c+3, where the winner's ack appears with the data read at grant.
    int            m_ack_at    = -1;
    int            m_we_at     = -1;
    int            m_addr_at   = -1;
    int            m_next_free = 0;
    req_id_e       m_who       = REQ_CPU;
    logic          m_wr        = 1'b0;
    logic [AW-1:0] m_gaddr     = '0;
    logic [DW-1:0] m_gwdata    = '0;
    logic [DW-1:0] m_data      = '0;
`ifdef RAM_ARB_RR_EN
    req_id_e       m_last      = REQ_PROG;
`endif

    always @(negedge clk) begin
        logic exp_cack, exp_pack, c_el, p_el;
        req_id_e w;
        if (rst) begin
            check("rst_outputs",
                  {bus.cpu_ack, bus.prog_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                   bus.cpu_rdata, bus.prog_rdata}, 32'd0);
            check("rst_stall", bus.cpu_stall, bus.cpu_req);
            m_ack_at    = -1;
            m_we_at     = -1;
            m_addr_at   = -1;
            m_next_free = 0;
`ifdef RAM_ARB_RR_EN
            m_last      = REQ_PROG;
`endif
        end else begin
            exp_cack = (m_ack_at == cyc) && (m_who == REQ_CPU);
            exp_pack = (m_ack_at == cyc) && (m_who == REQ_PROG);
            check("acks", {bus.cpu_ack, bus.prog_ack}, {exp_cack, exp_pack});
            check("cpu_stall", bus.cpu_stall, bus.cpu_req & ~exp_cack);
            check("ram_we", bus.ram_we, m_we_at == cyc);
            if (m_addr_at == cyc) begin
                check("ram_addr", bus.ram_addr, m_gaddr);
                if (m_wr) check("ram_wdata", bus.ram_wdata, m_gwdata);
            end
            if (exp_cack)          check("cpu_rdata", bus.cpu_rdata, m_data);
            if (exp_pack && !m_wr) check("prog_rdata", bus.prog_rdata, m_data);
            if (m_ack_at > cyc) begin
                if (m_who == REQ_CPU)
                    check("hold_cpu", {bus.cpu_req, bus.cpu_addr}, {1'b1, m_gaddr});
                else
                    check("hold_prog", {bus.prog_req, bus.prog_we, bus.prog_addr, bus.prog_wdata},
                          {1'b1, m_wr, m_gaddr, m_gwdata});
            end
            if (cyc >= m_next_free) begin
                c_el = bus.cpu_req  && !exp_cack;
                p_el = bus.prog_req && !exp_pack;
                if (c_el || p_el) begin
                    if (c_el && p_el) begin
`ifdef RAM_ARB_RR_EN
                        w = (m_last == REQ_CPU) ? REQ_PROG : REQ_CPU;
`else
                        w = REQ_CPU;
`endif
                    end else begin
                        w = c_el ? REQ_CPU : REQ_PROG;
                    end
`ifdef RAM_ARB_RR_EN
                    m_last = w;
`endif
                    m_who    = w;
                    m_gaddr  = (w == REQ_CPU) ? bus.cpu_addr : bus.prog_addr;
                    m_wr     = (w == REQ_PROG) && bus.prog_we;
                    m_gwdata = bus.prog_wdata;
                    if (m_wr) sb_mem[m_gaddr] = m_gwdata;
                    m_data      = sb_mem[m_gaddr];
                    m_ack_at    = cyc + 3;
                    m_we_at     = m_wr ? cyc + 1 : -1;
                    m_addr_at   = cyc + 1;
                    m_next_free = cyc + 3;
                end
            end
        end
    end

    task automatic cpu_txn(input logic [AW-1:0] addr, input bit keep,
                           output int ack_cyc, output logic [DW-1:0] data);
        bit seen = 1'b0;
        bus.cpu_addr = addr;
        bus.cpu_req  = 1'b1;
        ack_cyc = -1;
        data    = '0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                seen    = 1'b1;
                ack_cyc = cyc;
                data    = bus.cpu_rdata;
            end
        end
        check("cpu_ack_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.cpu_req = 1'b0;
    endtask

    task automatic prog_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input bit keep, output int ack_cyc, output logic [DW-1:0] data);
        bit seen = 1'b0;
        bus.prog_we    = we;
        bus.prog_addr  = addr;
        bus.prog_wdata = wdata;
        bus.prog_req   = 1'b1;
        ack_cyc = -1;
        data    = '0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.prog_ack) begin
                seen    = 1'b1;
                ack_cyc = cyc;
                data    = bus.prog_rdata;
            end
        end
        check("prog_ack_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.prog_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, sc, c1, c2, p1, p2, w0, a0;
        logic [DW-1:0] d1, d2, e1, e2;

        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = '0;
        bus.prog_req   = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = DW'(8'hA0 + i);
            sb_mem[i]  = DW'(8'hA0 + i);
        end
        env_mem[3] = 8'h2A;
        sb_mem[3]  = 8'h2A;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.cpu_ack, bus.prog_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata,
               bus.cpu_rdata, bus.prog_rdata, bus.cpu_stall}, 32'd0);
        rst = 1'b0;

        // Single CPU read of RAM[3].
        s = cyc;
        fork
            cpu_txn(4'd3, 1'b0, c1, d1);
            begin
                sc = 0;
                repeat (4) begin
                    @(negedge clk);
                    sc += int'(bus.cpu_stall);
                end
            end
        join
        check("t1_latency", c1 - s, 3);
        check("t1_data", d1, 8'h2A);
        check("t1_stall_cycles", sc, 3);

        // Loader write then read back, single write strobe.
        w0 = we_count;
        s = cyc;
        prog_txn(1'b1, 4'd9, 8'h5C, 1'b0, p1, e1);
        check("t2_wr_latency", p1 - s, 3);
        prog_txn(1'b0, 4'd9, 8'h00, 1'b0, p2, e2);
        check("t2_rd_data", e2, 8'h5C);
        check("t2_we_cycles", we_count - w0, 1);

        // Both requesters held: accesses alternate every 3 cycles.
        s = cyc;
        fork
            begin
                cpu_txn(4'd3, 1'b1, c1, d1);
                cpu_txn(4'd5, 1'b0, c2, d2);
            end
            begin
                prog_txn(1'b0, 4'd9, 8'h00, 1'b1, p1, e1);
                prog_txn(1'b0, 4'd15, 8'h00, 1'b0, p2, e2);
            end
        join
        check("t3_cpu_ack1", c1 - s, 3);
        check("t3_prog_ack1", p1 - s, 6);
        check("t3_cpu_ack2", c2 - s, 9);
        check("t3_prog_ack2", p2 - s, 12);
        check("t3_data", {d1, e1, d2, e2}, {8'h2A, 8'h5C, 8'hA5, 8'hAF});

        // Non-preemption: loader first, CPU one cycle later.
        s = cyc;
        fork
            prog_txn(1'b0, 4'd9, 8'h00, 1'b0, p1, e1);
            begin
                @(posedge clk);
                #1;
                cpu_txn(4'd3, 1'b0, c1, d1);
            end
        join
        check("t4_prog_ack", p1 - s, 3);
        check("t4_cpu_ack", c1 - s, 6);

        // Address extremes, no aliasing.
        prog_txn(1'b1, 4'd15, 8'hFF, 1'b0, p1, e1);
        prog_txn(1'b1, 4'd0,  8'h01, 1'b0, p1, e1);
        prog_txn(1'b0, 4'd15, 8'h00, 1'b0, p1, e1);
        check("t5_rd15", e1, 8'hFF);
        prog_txn(1'b0, 4'd0, 8'h00, 1'b0, p1, e1);
        check("t5_rd0", e1, 8'h01);
        cpu_txn(4'd1, 1'b0, c1, d1);
        check("t5_rd1", d1, 8'hA1);

        // Reset while a loader write is in ISSUE, then re-issue it.
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 4'd6;
        bus.prog_wdata = 8'h77;
        bus.prog_req   = 1'b1;
        @(posedge clk);
        #1;
        check("t6_we_in_issue", bus.ram_we, 1'b1);
        rst          = 1'b1;
        bus.prog_req = 1'b0;
        bus.prog_we  = 1'b0;
        #1;
        check("t6_rst_outputs",
              {bus.cpu_ack, bus.prog_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata,
               bus.cpu_rdata, bus.prog_rdata}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        a0 = pack_count;
        s  = cyc;
        prog_txn(1'b1, 4'd6, 8'h77, 1'b0, p1, e1);
        repeat (4) @(negedge clk);
        check("t6_rewrite_latency", p1 - s, 3);
        check("t6_single_ack", pack_count - a0, 1);
        @(posedge clk);
        #1;
        prog_txn(1'b0, 4'd6, 8'h00, 1'b0, p1, e1);
        check("t6_readback", e1, 8'h77);

        // Fresh simultaneous requests: CPU wins after a loader grant in both modes.
        s = cyc;
        fork
            cpu_txn(4'd0, 1'b0, c1, d1);
            prog_txn(1'b0, 4'd15, 8'h00, 1'b0, p1, e1);
        join
        check("t7_cpu_first", c1 - s, 3);
        check("t7_prog_second", p1 - s, 6);
        check("t7_data", {d1, e1}, {8'h01, 8'hFF});

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
